// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the op encodings presented on muldiv_seq.op and the FSM state type.
// No ports; imported by muldiv_seq.
package muldiv_pkg;

  // Operation encodings (all unsigned)
  localparam logic [1:0] OP_MUL   = 2'b00;  // low half of product
  localparam logic [1:0] OP_MULHU = 2'b01;  // high half of product
  localparam logic [1:0] OP_DIVU  = 2'b10;  // quotient
  localparam logic [1:0] OP_REMU  = 2'b11;  // remainder

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_seq_cla.sv
// Carry-lookahead adder/subtractor shared by every multiply/divide iteration.
// Purely combinational; no backpressure. Ports: a, b operands; subEn=1 computes
// a-b (cout=1 means no borrow); result is the WIDTH-bit sum/difference, cout the carry out.
module muldiv_seq_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subEn,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  // Subtraction as a + ~b + 1: invert b and feed subEn in as carry-in.
  assign bx = b ^ {WIDTH{subEn}};
  assign g  = a & bx;
  assign p  = a ^ bx;

  // Carries resolved in 2-bit lookahead groups (WIDTH is always even):
  // the carry out of each pair comes straight from the pair's group
  // generate/propagate and the pair's carry-in.
  always_comb begin
    c    = '0;
    c[0] = subEn;
    for (int k = 0; k < WIDTH / 2; k++) begin
      c[2*k+1] = g[2*k] | (p[2*k] & c[2*k]);
      c[2*k+2] = (g[2*k+1] | (p[2*k+1] & g[2*k])) | (p[2*k+1] & p[2*k] & c[2*k]);
    end
  end

  assign result = p ^ c[WIDTH-1:0];
  assign cout   = c[WIDTH];

endmodule

// File: rtl/muldiv_seq.sv
// Sequential unsigned MUL/MULHU/DIVU/REMU: shift-add multiply, restoring divide, one shared CLA.
// Latency: done pulses WIDTH+1 edges after the accepting edge (counted inclusively).
// No backpressure: start is accepted in IDLE/DONE and ignored while busy.
// Optional MULDIV_EARLY_OUT_EN: b==0 skips iteration, done on the accepting edge.
// Ports: clk, rst (async active-high), start, op, a, b in; busy, done, result out.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_hi;   // multiply: upper product / divide: partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiply: multiplier->lower product / divide: dividend->quotient

  logic             is_div;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] cla_a;
  logic [WIDTH-1:0] cla_b;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_cout;
  logic             take;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH-1:0] fin;

  assign is_div = op_q[1];
  assign rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};

  // Multiply adds b only when the current multiplier bit is set; adding zero
  // otherwise leaves the accumulator unchanged with cout=0.
  assign cla_a = is_div ? rem_sh : acc_hi;
  assign cla_b = (is_div || acc_lo[0]) ? b_q : '0;

  muldiv_seq_cla #(.WIDTH(WIDTH)) u_cla (
    .a      (cla_a),
    .b      (cla_b),
    .subEn  (is_div),
    .result (cla_sum),
    .cout   (cla_cout)
  );

  always_comb begin
    take   = 1'b0;
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (is_div) begin
      // The bit shifted out of the remainder makes it >= 2^WIDTH > b, so the
      // subtraction is valid even when the CLA reports a borrow.
      take   = cla_cout | acc_hi[WIDTH-1];
      nxt_hi = take ? cla_sum : rem_sh;
      nxt_lo = {acc_lo[WIDTH-2:0], take};
    end else begin
      nxt_hi = {cla_cout, cla_sum[WIDTH-1:1]};
      nxt_lo = {cla_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // MULHU and REMU live in the upper accumulator, MUL and DIVU in the lower.
  assign fin = op_q[0] ? nxt_hi : nxt_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_MUL;
      b_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            b_q    <= b;
            acc_hi <= '0;
            acc_lo <= a;
            cnt    <= CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
            if (b == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              case (op)
                OP_DIVU: result <= '1;
                OP_REMU: result <= a;
                default: result <= '0;
              endcase
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          if (cnt == '0) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= fin;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
